verdict_collector: RTL and testbench

- Downstream stage of the RTLola monitor (topEntity). Consumes its per-output value/aktv pairs.
- Each cycle with at least one active output is captured as a frame into a small FIFO.
- Frames are serialized onto a DATA_W-wide valid/ready stream for a host/UART/DMA sink: header word first, then the values of active outputs only.
- Overflow is reported, never stalls the monitor; the monitor has no back-pressure input.

---
 rtl/verdict_collector.sv | 263 ++++++++++++++++++++++++++
 tb/tb_verdict_collector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/verdict_collector.sv
// verdict_collector
//   Collects per-cycle verdicts from the RTLola monitor into a small frame
//   FIFO and serializes them onto a valid/ready word stream.
//   A frame is one header word {ts, mask} followed by the values of the
//   outputs set in mask, lowest index first. The monitor cannot be stalled.
//   If a frame arrives while the FIFO is full and nothing is popped in that
//   cycle, the frame is dropped and counted.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   en        global enable; gates capture and the timestamp counter
//   out_val   monitor values, output i at [i*DATA_W +: DATA_W]
//   out_aktv  per-output activity flags
//   m_data    stream word (registered)
//   m_valid   stream word valid (registered)
//   m_ready   sink ready
//   m_last    last word of the current frame (registered)
//   overflow  sticky flag: at least one frame has been dropped
//   drop_cnt  dropped-frame count, saturating at all-ones
//
// Build option
//   VERDICT_COLLECTOR_TIMESTAMP_EN : when defined, builds the timestamp
//   counter and puts it in the header. When undefined, the header ts field
//   is zero.
//
// Serializer states
//   state  | meaning
//   S_IDLE | no frame in flight; loads the FIFO head when one is available
//   S_HDR  | header word presented
//   S_DATA | value words presented, walking rem from its lowest set bit

module verdict_collector #(
    parameter int NUM_OUT = 6,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_OUT*DATA_W-1:0] out_val,
    input  logic [NUM_OUT-1:0]        out_aktv,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int TS_W  = DATA_W - NUM_OUT;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int VAL_W = NUM_OUT * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } state_t;

    // ------------------------------------------------------------------
    // Timestamp
    // ------------------------------------------------------------------
    logic [TS_W-1:0] ts;

`ifdef VERDICT_COLLECTOR_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q;
        if (en) begin
            ts_d = ts_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign ts = ts_q;
`else
    assign ts = '0;
`endif

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] hdr_mem [DEPTH];
    logic [VAL_W-1:0]  val_mem [DEPTH];

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              empty, full;
    logic              capture, push, pop, drop;
    logic [DATA_W-1:0] head_hdr;
    logic [VAL_W-1:0]  head_val;

    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign capture  = en && (|out_aktv);
    // A pop in the same cycle frees the slot being written, so a full FIFO
    // still accepts the frame.
    assign push     = capture && (!full || pop);
    assign drop     = capture && full && !pop;
    assign head_hdr = hdr_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_val = val_mem[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    // Frame storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            hdr_mem[wr_ptr_q[PTR_W-1:0]] <= {ts, out_aktv};
            val_mem[wr_ptr_q[PTR_W-1:0]] <= out_val;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [NUM_OUT-1:0]  rem_q, rem_d;
    logic [VAL_W-1:0]    shadow_q, shadow_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [NUM_OUT-1:0]  rem_clr;

    function automatic logic [DATA_W-1:0] pick_low(input logic [NUM_OUT-1:0] r,
                                                   input logic [VAL_W-1:0]   v);
        pick_low = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (r[i]) begin
                pick_low = v[i*DATA_W +: DATA_W];
            end
        end
    endfunction

    function automatic logic is_onehot(input logic [NUM_OUT-1:0] r);
        is_onehot = (r != '0) && ((r & (r - NUM_OUT'(1))) == '0);
    endfunction

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        shadow_d  = shadow_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        pop       = 1'b0;
        rem_clr   = rem_q & (rem_q - NUM_OUT'(1));

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shadow_d  = head_val;
                    rem_d     = head_hdr[NUM_OUT-1:0];
                    m_valid_d = 1'b1;
                    m_data_d  = head_hdr;
                    m_last_d  = 1'b0;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                if (m_ready) begin
                    m_data_d = pick_low(rem_q, shadow_q);
                    m_last_d = is_onehot(rem_q);
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (m_ready) begin
                    if (rem_clr == '0) begin
                        // Chain straight into the next header when one is waiting.
                        if (!empty) begin
                            pop       = 1'b1;
                            shadow_d  = head_val;
                            rem_d     = head_hdr[NUM_OUT-1:0];
                            m_valid_d = 1'b1;
                            m_data_d  = head_hdr;
                            m_last_d  = 1'b0;
                            state_d   = S_HDR;
                        end else begin
                            rem_d     = '0;
                            m_valid_d = 1'b0;
                            m_last_d  = 1'b0;
                            state_d   = S_IDLE;
                        end
                    end else begin
                        rem_d    = rem_clr;
                        m_data_d = pick_low(rem_clr, shadow_q);
                        m_last_d = is_onehot(rem_clr);
                    end
                end
            end
            default: begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            state_q    <= S_IDLE;
            rem_q      <= '0;
            shadow_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
            rem_q      <= rem_d;
            shadow_q   <= shadow_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_data_q   <= m_data_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_data   = m_data_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_verdict_collector.sv
module tb_verdict_collector;

    localparam int NUM_OUT = 6;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;

`ifdef VERDICT_COLLECTOR_TIMESTAMP_EN
    localparam logic [63:0] TS_FIELD  = {{58{1'b1}}, 6'd0};
    localparam logic [63:0] HDR_BASIC = 64'd645;
`else
    localparam logic [63:0] TS_FIELD  = 64'd0;
    localparam logic [63:0] HDR_BASIC = 64'd5;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      en = 1'b0;
    logic [NUM_OUT*DATA_W-1:0] out_val = '0;
    logic [NUM_OUT-1:0]        out_aktv = '0;
    logic [DATA_W-1:0]         m_data;
    logic                      m_valid;
    logic                      m_ready = 1'b0;
    logic                      m_last;
    logic                      overflow;
    logic [CNT_W-1:0]          drop_cnt;

    int          total = 0;
    int          bad = 0;
    int unsigned ts_cnt = 0;

    typedef struct packed {
        logic [5:0]   aktv;
        logic [383:0] vals;
        logic [3:0]   n;
        logic [383:0] exp;
    } vec_t;

    vec_t vecs [4];

    verdict_collector #(
        .NUM_OUT(NUM_OUT),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .out_val (out_val),
        .out_aktv(out_aktv),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] exp_hdr(input int unsigned t, input logic [5:0] m);
        exp_hdr = ((64'(t) << 6) & TS_FIELD) | {58'd0, m};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clock; counts the edge for the timestamp if enabled and out of reset.
    task automatic tick();
        bit e;
        e = en && rst;
        @(posedge clk);
        #1;
        if (e) ts_cnt++;
    endtask

    task automatic capture(input logic [5:0] a, input logic [383:0] v, output int unsigned t);
        en       = 1'b1;
        out_aktv = a;
        out_val  = v;
        t        = ts_cnt;
        tick();
        out_aktv = '0;
    endtask

    task automatic collect_frame(input logic [63:0] hdr, input int n,
                                 input logic [383:0] exp, input string nm);
        int          w;
        logic [63:0] ew;
        m_ready = 1'b1;
        for (int j = 0; j <= n; j++) begin
            w = 0;
            while (!m_valid && w < 20) begin
                tick();
                w++;
            end
            if (!m_valid) begin
                total++;
                bad++;
                $display("FAIL %s_w%0d_timeout actual=no_valid required=valid", nm, j);
                return;
            end
            ew = (j == 0) ? hdr : exp[(j-1)*64 +: 64];
            check($sformatf("%s_w%0d_data", nm, j), m_data, ew);
            check($sformatf("%s_w%0d_last", nm, j), 64'(m_last), 64'(j == n));
            tick();
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int unsigned t;
        m_ready = 1'b1;
        capture(v.aktv, v.vals, t);
        check({nm, "_lat1"}, 64'(m_valid), 64'd0);
        tick();
        check({nm, "_lat2"}, 64'(m_valid), 64'd1);
        collect_frame(exp_hdr(t, v.aktv), int'(v.n), v.exp, nm);
        check({nm, "_end"}, 64'(m_valid), 64'd0);
    endtask

    initial begin
        int unsigned t;
        int unsigned tk [6];

        vecs[0] = '{aktv: 6'b000101,
                    vals: {64'hDEAD, 64'hDEAD, 64'hDEAD, 64'd3, 64'hDEAD, 64'd1},
                    n: 4'd2, exp: {256'd0, 64'd3, 64'd1}};
        vecs[1] = '{aktv: 6'b111111,
                    vals: {64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1},
                    n: 4'd6,
                    exp: {64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1}};
        vecs[2] = '{aktv: 6'b100000,
                    vals: {64'h8000_0000_0000_0000, {5{64'hBEEF}}},
                    n: 4'd1, exp: {320'd0, 64'h8000_0000_0000_0000}};
        vecs[3] = '{aktv: 6'b010010,
                    vals: {64'h55, 64'hFFFF_FFFF_FFFF_FFFB, 64'h77, 64'h66, 64'h1234, 64'h11},
                    n: 4'd2, exp: {256'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'h1234}};

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_last", 64'(m_last), 64'd0);
        check("rst_data", m_data, 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        rst    = 1'b1;
        ts_cnt = 0;

        // Basic frame at ts=10
        en      = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        out_aktv = 6'b000101;
        out_val  = vecs[0].vals;
        tick();
        out_aktv = '0;
        check("basic_lat1", 64'(m_valid), 64'd0);
        tick();
        check("basic_lat2", 64'(m_valid), 64'd1);
        check("basic_hdr", m_data, HDR_BASIC);
        collect_frame(HDR_BASIC, 2, vecs[0].exp, "basic");

        // Table vectors
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // en=0: no capture, timestamp frozen
        en       = 1'b0;
        out_aktv = 6'b000011;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("en0_valid%0d", i), 64'(m_valid), 64'd0);
        end
        out_aktv = '0;
        run_vec(vecs[3], "en0_after");

        // Back-pressure on the header
        m_ready = 1'b0;
        capture(vecs[0].aktv, vecs[0].vals, t);
        tick();
        check("bp_valid", 64'(m_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), 64'(m_valid), 64'd1);
            check($sformatf("bp_hold_data%0d", i), m_data, exp_hdr(t, 6'b000101));
            check($sformatf("bp_hold_last%0d", i), 64'(m_last), 64'd0);
        end
        collect_frame(exp_hdr(t, 6'b000101), 2, vecs[0].exp, "bp");
        check("bp_no_dup", 64'(m_valid), 64'd0);

        // Overflow: six captures with the sink stalled
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            capture(6'b000001, {320'd0, 64'(100 + k)}, tk[k]);
        end
        check("ovf_drop", 64'(drop_cnt), 64'd1);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_hdr0", m_data, exp_hdr(tk[0], 6'b000001));

        // Full FIFO with a pop on the capture cycle
        m_ready = 1'b1;
        tick();
        check("fp_data0", m_data, 64'd100);
        check("fp_last0", 64'(m_last), 64'd1);
        capture(6'b000001, {320'd0, 64'd200}, t);
        check("fp_drop", 64'(drop_cnt), 64'd1);
        check("fp_hdr1", m_data, exp_hdr(tk[1], 6'b000001));
        for (int k = 1; k < 5; k++) begin
            collect_frame(exp_hdr(tk[k], 6'b000001), 1, {320'd0, 64'(100 + k)},
                          $sformatf("drain%0d", k));
        end
        collect_frame(exp_hdr(t, 6'b000001), 1, {320'd0, 64'd200}, "drain_fp");
        check("drain_end", 64'(m_valid), 64'd0);
        check("drain_drop", 64'(drop_cnt), 64'd1);

        // Reset in the middle of a frame
        m_ready = 1'b1;
        capture(vecs[1].aktv, vecs[1].vals, t);
        tick();
        tick();
        check("mr_pre_data", m_data, 64'd1);
        check("mr_pre_valid", 64'(m_valid), 64'd1);
        rst = 1'b0;
        #1;
        check("mr_valid", 64'(m_valid), 64'd0);
        check("mr_last", 64'(m_last), 64'd0);
        check("mr_data", m_data, 64'd0);
        check("mr_ovf", 64'(overflow), 64'd0);
        check("mr_drop", 64'(drop_cnt), 64'd0);
        ts_cnt = 0;
        tick();
        rst = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("mr_stale%0d", i), 64'(m_valid), 64'd0);
        end
        capture(6'b000001, {320'd0, 64'd7}, t);
        check("mr_ts0_lat1", 64'(m_valid), 64'd0);
        tick();
        check("mr_ts0_lat2", 64'(m_valid), 64'd1);
        collect_frame(exp_hdr(0, 6'b000001), 1, {320'd0, 64'd7}, "mr_ts0");
        check("mr_ts0_end", 64'(m_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
